tetris_vga_renderer: RTL and testbench



---
 rtl/tetris_vga_renderer.sv | 120 ++++++++++++
 tb/tb_tetris_vga_renderer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_vga_renderer.sv
// 640x480@60 VGA renderer for a 10x20 tetris board: 25 MHz pixel tick from a toggle FF,
// board snapshotted once per frame in vertical blank, 1-tick registered output pipeline.
module tetris_vga_renderer #(
    parameter int          FIELD_X0   = 240,
    parameter int          FIELD_Y0   = 80,
    parameter int          BORDER     = 4,
    parameter logic [23:0] FILL_RGB   = 24'h00C0FF,
    parameter logic [23:0] EMPTY_RGB  = 24'h202020,
    parameter int          CELL_SHIFT = 4,
    parameter int          H_VIS      = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_VIS      = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [199:0] board,
    output logic         vga_HS,
    output logic         vga_VS,
    output logic         vga_blank_n,
    output logic [7:0]   R,
    output logic [7:0]   G,
    output logic [7:0]   B,
    output logic         frame_start
);
    localparam int FW = 10 << CELL_SHIFT;
    localparam int FH = 20 << CELL_SHIFT;

    localparam logic [9:0] HV  = 10'(H_VIS);
    localparam logic [9:0] HSS = 10'(H_VIS + H_FP);
    localparam logic [9:0] HSE = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] HL  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VV  = 10'(V_VIS);
    localparam logic [9:0] VSS = 10'(V_VIS + V_FP);
    localparam logic [9:0] VSE = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] VL  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] FX0 = 10'(FIELD_X0);
    localparam logic [9:0] FX1 = 10'(FIELD_X0 + FW);
    localparam logic [9:0] FY0 = 10'(FIELD_Y0);
    localparam logic [9:0] FY1 = 10'(FIELD_Y0 + FH);
    localparam logic [9:0] BX0 = 10'(FIELD_X0 - BORDER);
    localparam logic [9:0] BX1 = 10'(FIELD_X0 + FW + BORDER);
    localparam logic [9:0] BY0 = 10'(FIELD_Y0 - BORDER);
    localparam logic [9:0] BY1 = 10'(FIELD_Y0 + FH + BORDER);

    logic         r_pix_en;
    logic [9:0]   r_hcnt, r_vcnt;
    logic [199:0] r_snap;

    logic         w_vis, w_field, w_frame, w_hs, w_vs, w_cell;
    logic [9:0]   w_dx, w_dy;
    logic [3:0]   w_col;
    logic [4:0]   w_row;
    logic [7:0]   w_idx;
    logic [23:0]  w_rgb;

    assign w_vis   = (r_hcnt < HV) && (r_vcnt < VV);
    assign w_field = (r_hcnt >= FX0) && (r_hcnt < FX1) && (r_vcnt >= FY0) && (r_vcnt < FY1);
    assign w_frame = (r_hcnt >= BX0) && (r_hcnt < BX1) && (r_vcnt >= BY0) && (r_vcnt < BY1);
    assign w_hs    = !((r_hcnt >= HSS) && (r_hcnt < HSE));
    assign w_vs    = !((r_vcnt >= VSS) && (r_vcnt < VSE));

    // Offsets are only meaningful inside the field; w_field gates their use.
    assign w_dx   = r_hcnt - FX0;
    assign w_dy   = r_vcnt - FY0;
    assign w_col  = 4'(w_dx >> CELL_SHIFT);
    assign w_row  = 5'(w_dy >> CELL_SHIFT);
    assign w_idx  = {3'd0, w_row} * 8'd10 + {4'd0, w_col};
    assign w_cell = r_snap[8'd199 - w_idx];

    always_comb begin
        w_rgb = 24'h000000;
        if (w_vis) begin
            if (w_field)
                w_rgb = w_cell ? FILL_RGB : EMPTY_RGB;
            else if (w_frame)
                w_rgb = 24'hFFFFFF;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pix_en    <= 1'b0;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_snap      <= '0;
            vga_HS      <= 1'b1;
            vga_VS      <= 1'b1;
            vga_blank_n <= 1'b0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
            frame_start <= 1'b0;
        end else begin
            r_pix_en    <= ~r_pix_en;
            frame_start <= 1'b0;
            if (r_pix_en) begin
                vga_HS      <= w_hs;
                vga_VS      <= w_vs;
                vga_blank_n <= w_vis;
                {R, G, B}   <= w_rgb;
                if (r_hcnt == HL) begin
                    r_hcnt <= '0;
                    r_vcnt <= (r_vcnt == VL) ? 10'd0 : r_vcnt + 10'd1;
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end
                // First blank pixel of the vertical blank: safe point to take a new board.
                if (r_hcnt == 10'd0 && r_vcnt == VV) begin
                    r_snap      <= board;
                    frame_start <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Bench for tetris_vga_renderer: full-size instance for line timing and reset behaviour,
// a shrunken-geometry instance for whole-frame rendering, snapshot and reset-mid-frame scenarios.
`timescale 1ns/1ps
module tb_tetris_vga_renderer;
    typedef struct packed {
        int fx0; int fy0; int brd; int cs;
        int hvis; int hfp; int hsync; int hbp;
        int vvis; int vfp; int vsync; int vbp;
    } cfg_t;
    typedef struct packed {
        logic hs; logic vs; logic bn; logic [23:0] rgb;
    } vout_t;

    localparam cfg_t CF = '{240, 80, 4, 4, 640, 16, 96, 48, 480, 10, 2, 33};
    localparam cfg_t CS = '{4, 4, 2, 1, 32, 4, 6, 6, 50, 3, 2, 5};
    localparam vout_t RST_OUT = '{1'b1, 1'b1, 1'b0, 24'h000000};
    localparam logic [23:0] FILL  = 24'h00C0FF;
    localparam logic [23:0] EMPTY = 24'h202020;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam int SFRAME_CLK = 2 * (32 + 4 + 6 + 6) * (50 + 3 + 2 + 5);

    logic clk = 1'b0;
    logic rstn_f, rstn_s;
    logic [199:0] board;
    logic hs_f, vs_f, bn_f, fs_f, hs_s, vs_s, bn_s, fs_s;
    logic [7:0] r_f, g_f, b_f, r_s, g_s, b_s;
    vout_t o_f, o_s;
    int checks = 0, failures = 0;

    always #10 clk = ~clk;

    tetris_vga_renderer dut_f (
        .clk(clk), .resetn(rstn_f), .board(board),
        .vga_HS(hs_f), .vga_VS(vs_f), .vga_blank_n(bn_f),
        .R(r_f), .G(g_f), .B(b_f), .frame_start(fs_f)
    );

    tetris_vga_renderer #(
        .FIELD_X0(CS.fx0), .FIELD_Y0(CS.fy0), .BORDER(CS.brd), .CELL_SHIFT(CS.cs),
        .H_VIS(CS.hvis), .H_FP(CS.hfp), .H_SYNC(CS.hsync), .H_BP(CS.hbp),
        .V_VIS(CS.vvis), .V_FP(CS.vfp), .V_SYNC(CS.vsync), .V_BP(CS.vbp)
    ) dut_s (
        .clk(clk), .resetn(rstn_s), .board(board),
        .vga_HS(hs_s), .vga_VS(vs_s), .vga_blank_n(bn_s),
        .R(r_s), .G(g_s), .B(b_s), .frame_start(fs_s)
    );

    assign o_f = {hs_f, vs_f, bn_f, r_f, g_f, b_f};
    assign o_s = {hs_s, vs_s, bn_s, r_s, g_s, b_s};

    // ---------------- reference model ----------------
    function automatic int htot(cfg_t c); return c.hvis + c.hfp + c.hsync + c.hbp; endfunction
    function automatic int vtot(cfg_t c); return c.vvis + c.vfp + c.vsync + c.vbp; endfunction
    // Edge e after release is a pixel tick when even; it displays pixel number e/2-1.
    function automatic int pix_h(cfg_t c, int e); return (e / 2 - 1) % htot(c); endfunction
    function automatic int pix_v(cfg_t c, int e); return ((e / 2 - 1) / htot(c)) % vtot(c); endfunction

    function automatic vout_t model_px(cfg_t c, int h, int v, logic [199:0] s);
        vout_t o;
        int fw, fh, row, col;
        fw = 10 << c.cs;
        fh = 20 << c.cs;
        o.hs  = !(h >= c.hvis + c.hfp && h < c.hvis + c.hfp + c.hsync);
        o.vs  = !(v >= c.vvis + c.vfp && v < c.vvis + c.vfp + c.vsync);
        o.bn  = (h < c.hvis) && (v < c.vvis);
        o.rgb = 24'h000000;
        if (o.bn) begin
            if (h >= c.fx0 && h < c.fx0 + fw && v >= c.fy0 && v < c.fy0 + fh) begin
                col = (h - c.fx0) / (1 << c.cs);
                row = (v - c.fy0) / (1 << c.cs);
                o.rgb = s[199 - (row * 10 + col)] ? FILL : EMPTY;
            end else if (h >= c.fx0 - c.brd && h < c.fx0 + fw + c.brd &&
                         v >= c.fy0 - c.brd && v < c.fy0 + fh + c.brd) begin
                o.rgb = WHITE;
            end
        end
        return o;
    endfunction

    int e_f = 0, ph_f = 0, pv_f = 0;
    logic [199:0] ms_f = '0;
    vout_t x_f = RST_OUT;
    logic xfs_f = 1'b0;
    always @(posedge clk or negedge rstn_f) begin
        if (!rstn_f) begin
            e_f <= 0; ms_f <= '0; x_f <= RST_OUT; xfs_f <= 1'b0; ph_f <= 0; pv_f <= 0;
        end else begin
            e_f   <= e_f + 1;
            xfs_f <= 1'b0;
            if ((e_f + 1) % 2 == 0) begin
                ph_f <= pix_h(CF, e_f + 1);
                pv_f <= pix_v(CF, e_f + 1);
                x_f  <= model_px(CF, pix_h(CF, e_f + 1), pix_v(CF, e_f + 1), ms_f);
                if (pix_h(CF, e_f + 1) == 0 && pix_v(CF, e_f + 1) == CF.vvis) begin
                    ms_f <= board; xfs_f <= 1'b1;
                end
            end
        end
    end

    int e_s = 0, ph_s = 0, pv_s = 0;
    logic [199:0] ms_s = '0;
    vout_t x_s = RST_OUT;
    logic xfs_s = 1'b0;
    always @(posedge clk or negedge rstn_s) begin
        if (!rstn_s) begin
            e_s <= 0; ms_s <= '0; x_s <= RST_OUT; xfs_s <= 1'b0; ph_s <= 0; pv_s <= 0;
        end else begin
            e_s   <= e_s + 1;
            xfs_s <= 1'b0;
            if ((e_s + 1) % 2 == 0) begin
                ph_s <= pix_h(CS, e_s + 1);
                pv_s <= pix_v(CS, e_s + 1);
                x_s  <= model_px(CS, pix_h(CS, e_s + 1), pix_v(CS, e_s + 1), ms_s);
                if (pix_h(CS, e_s + 1) == 0 && pix_v(CS, e_s + 1) == CS.vvis) begin
                    ms_s <= board; xfs_s <= 1'b1;
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        board = '1; rstn_f = 1'b0; rstn_s = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (o_f !== RST_OUT) begin failures++; $display("FAIL reset_full_out got=%h exp=%h", o_f, RST_OUT); end
        checks++; if (o_s !== RST_OUT) begin failures++; $display("FAIL reset_small_out got=%h exp=%h", o_s, RST_OUT); end
        checks++; if (fs_f !== 1'b0) begin failures++; $display("FAIL reset_full_fs got=%b exp=0", fs_f); end
        checks++; if (fs_s !== 1'b0) begin failures++; $display("FAIL reset_small_fs got=%b exp=0", fs_s); end
    endtask

    task automatic test_line_timing();
        int fall[$];
        int rise[$];
        logic prev;
        board = '0; rstn_f = 1'b1; prev = 1'b1;
        for (int k = 1; k <= 3240; k++) begin
            @(negedge clk);
            checks++;
            if (o_f !== x_f || fs_f !== xfs_f) begin
                failures++; $display("FAIL line_px e=%0d got=%h/%b exp=%h/%b", e_f, o_f, fs_f, x_f, xfs_f);
            end
            if (prev && !o_f.hs) fall.push_back(k);
            if (!prev && o_f.hs) rise.push_back(k);
            prev = o_f.hs;
        end
        checks++; if (fall.size() != 2) begin failures++; $display("FAIL hs_fall_count got=%0d exp=2", fall.size()); end
        if (fall.size() >= 1) begin
            checks++; if (fall[0] != 1314) begin failures++; $display("FAIL hs_first_fall got=%0d exp=1314", fall[0]); end
        end
        if (fall.size() >= 2) begin
            checks++; if (fall[1] - fall[0] != 1600) begin failures++; $display("FAIL hs_period got=%0d exp=1600", fall[1] - fall[0]); end
        end
        if (rise.size() >= 1 && fall.size() >= 1) begin
            checks++; if (rise[0] - fall[0] != 192) begin failures++; $display("FAIL hs_width got=%0d exp=192", rise[0] - fall[0]); end
        end
    endtask

    task automatic test_reset_full_mid();
        int cnt;
        for (int k = 0; k < 4000 && ph_f != 300; k++) @(negedge clk);
        checks++; if (ph_f != 300) begin failures++; $display("FAIL wait_full_h300 got=%0d exp=300", ph_f); end
        #2 rstn_f = 1'b0;
        #1;
        checks++; if (o_f !== RST_OUT) begin failures++; $display("FAIL async_reset_full got=%h exp=%h", o_f, RST_OUT); end
        checks++; if (fs_f !== 1'b0) begin failures++; $display("FAIL async_reset_full_fs got=%b exp=0", fs_f); end
        repeat (2) @(negedge clk);
        rstn_f = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            cnt++;
            checks++;
            if (o_f !== x_f) begin failures++; $display("FAIL restart_px e=%0d got=%h exp=%h", e_f, o_f, x_f); end
            if (!o_f.hs) break;
        end
        checks++; if (cnt != 1314) begin failures++; $display("FAIL restart_hs_fall got=%0d exp=1314", cnt); end
    endtask

    task automatic test_frames();
        logic [199:0] pats [4];
        int fs_at[$];
        int fs_cnt, vs_low, n;
        pats[0] = '0; pats[0][199] = 1'b1;
        pats[1] = '0; pats[1][0] = 1'b1;
        for (int i = 0; i < 200; i++) pats[2][i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 200; i++) pats[3][i] = 1'($urandom_range(0, 1));
        board = '0; rstn_s = 1'b1; n = 0;
        for (int w = 0; w < 5; w++) begin
            board = pats[(w < 4) ? w : 3];
            fs_cnt = 0; vs_low = 0;
            for (int k = 0; k < SFRAME_CLK; k++) begin
                @(negedge clk);
                n++;
                checks++;
                if (o_s !== x_s || fs_s !== xfs_s) begin
                    failures++; $display("FAIL frame_px w=%0d h=%0d v=%0d got=%h/%b exp=%h/%b", w, ph_s, pv_s, o_s, fs_s, x_s, xfs_s);
                end
                if (fs_s) begin fs_cnt++; fs_at.push_back(n); end
                if (!o_s.vs) vs_low++;
                if (w == 0 && ph_s == 0 && pv_s == 0) begin
                    checks++; if (o_s.rgb !== 24'h0) begin failures++; $display("FAIL px_origin got=%h exp=000000", o_s.rgb); end
                end
                if (w == 0 && ph_s == CS.fx0 && pv_s == CS.fy0) begin
                    checks++; if (o_s.rgb !== EMPTY) begin failures++; $display("FAIL px_empty_cell got=%h exp=%h", o_s.rgb, EMPTY); end
                end
                if (w == 0 && ph_s == CS.fx0 - 1 && pv_s == CS.fy0) begin
                    checks++; if (o_s.rgb !== WHITE) begin failures++; $display("FAIL px_border got=%h exp=%h", o_s.rgb, WHITE); end
                end
                if (w == 0 && ph_s == CS.hvis + 2 && pv_s == CS.fy0) begin
                    checks++; if (o_s.rgb !== 24'h0) begin failures++; $display("FAIL px_hblank got=%h exp=000000", o_s.rgb); end
                end
                if (w == 1 && ph_s == CS.fx0 + 1 && pv_s == CS.fy0 + 1) begin
                    checks++; if (o_s.rgb !== FILL) begin failures++; $display("FAIL px_cell00_fill got=%h exp=%h", o_s.rgb, FILL); end
                end
                if (w == 1 && ph_s == CS.fx0 + 2 && pv_s == CS.fy0) begin
                    checks++; if (o_s.rgb !== EMPTY) begin failures++; $display("FAIL px_cell01_empty got=%h exp=%h", o_s.rgb, EMPTY); end
                end
                if (w == 2 && ph_s == CS.fx0 + 19 && pv_s == CS.fy0 + 39) begin
                    checks++; if (o_s.rgb !== FILL) begin failures++; $display("FAIL px_cell199_fill got=%h exp=%h", o_s.rgb, FILL); end
                end
            end
            checks++; if (fs_cnt != 1) begin failures++; $display("FAIL fs_per_frame w=%0d got=%0d exp=1", w, fs_cnt); end
            checks++; if (vs_low != 192) begin failures++; $display("FAIL vs_width w=%0d got=%0d exp=192", w, vs_low); end
        end
        for (int i = 1; i < fs_at.size(); i++) begin
            checks++;
            if (fs_at[i] - fs_at[i-1] != SFRAME_CLK) begin
                failures++; $display("FAIL frame_period got=%0d exp=%0d", fs_at[i] - fs_at[i-1], SFRAME_CLK);
            end
        end
    endtask

    task automatic test_board_change();
        logic seen;
        board = '0;
        for (int k = 0; k < 6000 && !xfs_s; k++) @(negedge clk);
        for (int k = 0; k < 6000 && pv_s != 20; k++) @(negedge clk);
        checks++; if (pv_s != 20) begin failures++; $display("FAIL wait_small_v20 got=%0d exp=20", pv_s); end
        board = '1; seen = 1'b0;
        for (int k = 0; k < 8640; k++) begin
            @(negedge clk);
            checks++;
            if (o_s !== x_s || fs_s !== xfs_s) begin
                failures++; $display("FAIL change_px h=%0d v=%0d got=%h/%b exp=%h/%b", ph_s, pv_s, o_s, fs_s, x_s, xfs_s);
            end
            if (!seen && ph_s == 0 && pv_s == CS.vvis) begin
                seen = 1'b1;
                checks++; if (fs_s !== 1'b1) begin failures++; $display("FAIL fs_at_vblank got=%b exp=1", fs_s); end
            end
            if (ph_s == CS.fx0 && pv_s == 30) begin
                checks++;
                if (o_s.rgb !== (seen ? FILL : EMPTY)) begin
                    failures++; $display("FAIL change_cell seen=%b got=%h exp=%h", seen, o_s.rgb, seen ? FILL : EMPTY);
                end
            end
        end
    endtask

    task automatic test_reset_small_mid();
        logic seen;
        for (int k = 0; k < 6000 && !(ph_s == 10 && pv_s == 20); k++) @(negedge clk);
        checks++; if (pv_s != 20) begin failures++; $display("FAIL wait_small_mid got=%0d exp=20", pv_s); end
        #2 rstn_s = 1'b0;
        #1;
        checks++; if (o_s !== RST_OUT) begin failures++; $display("FAIL async_reset_small got=%h exp=%h", o_s, RST_OUT); end
        repeat (2) @(negedge clk);
        rstn_s = 1'b1; seen = 1'b0;
        for (int k = 0; k < 7000; k++) begin
            @(negedge clk);
            checks++;
            if (o_s !== x_s || fs_s !== xfs_s) begin
                failures++; $display("FAIL rst_mid_px h=%0d v=%0d got=%h/%b exp=%h/%b", ph_s, pv_s, o_s, fs_s, x_s, xfs_s);
            end
            if (ph_s == 0 && pv_s == CS.vvis) seen = 1'b1;
            if (ph_s == CS.fx0 && pv_s == CS.fy0 && e_s > 2) begin
                checks++;
                if (o_s.rgb !== (seen ? FILL : EMPTY)) begin
                    failures++; $display("FAIL rst_mid_cell seen=%b got=%h exp=%h", seen, o_s.rgb, seen ? FILL : EMPTY);
                end
            end
        end
    endtask

    initial begin
        board = '0; rstn_f = 1'b0; rstn_s = 1'b0;
        test_reset();
        test_line_timing();
        test_reset_full_mid();
        test_frames();
        test_board_change();
        test_reset_small_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
